// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : corr_pkg
//  Description : Shared definitions for the correlation peak-detector path:
//                FSM state encodings and settings-register addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package corr_pkg;

    // Peak detector FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_SEARCH   = 3'd0,
        S_TRACK    = 3'd1,
        S_EMIT_IDX = 3'd2,
        S_EMIT_VAL = 3'd3,
        S_HOLDOFF  = 3'd4
    } peak_state_t;

    // Settings-register addresses for the peak detector configuration
    localparam int unsigned SR_PEAK_THRESH   = 135;
    localparam int unsigned SR_PEAK_WIN_HOLD = 136;
    localparam int unsigned SR_PEAK_CTRL     = 137;

endpackage : corr_pkg
`default_nettype wire

// File: rtl/corr_peak_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : corr_peak_detector_if
//  Description : AXI4-Stream style bundle (TDATA/TVALID/TREADY/TLAST) used
//                for both the correlation input and the result output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface corr_peak_detector_if #(
    parameter int DATA_W = 32
) ();

    logic [DATA_W-1:0] TDATA;
    logic              TVALID;
    logic              TREADY;
    logic              TLAST;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        output TREADY
    );

endinterface : corr_peak_detector_if
`default_nettype wire

// File: rtl/corr_abs_sat.sv
`default_nettype none
// ============================================================================
//  Module      : corr_abs_sat
//  Description : Combinational saturating absolute value of a signed sample.
//                The most negative input maps to the largest positive value,
//                so the result always fits in DATA_W-1 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module corr_abs_sat #(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] data,
    output logic      [DATA_W-2:0] mag
);

    logic w_neg;
    logic w_is_min;

    // Two's-complement negate on the low bits; the full-scale negative case saturates
    always_comb begin
        w_neg    = data[DATA_W-1];
        w_is_min = w_neg && (data[DATA_W-2:0] == '0);
        if (w_is_min) begin
            mag = '1;
        end else if (w_neg) begin
            mag = ~data[DATA_W-2:0] + (DATA_W-1)'(1);
        end else begin
            mag = data[DATA_W-2:0];
        end
    end

endmodule : corr_abs_sat
`default_nettype wire

// File: rtl/corr_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : corr_peak_detector
//  Description : Finds peaks in the signed correlation stream. A sample whose
//                magnitude exceeds the threshold opens a tracking window; the
//                largest magnitude in the window (earliest on ties) is emitted
//                as a two-word packet {index, magnitude}, followed by an
//                optional holdoff that discards sidelobe samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module corr_peak_detector
    import corr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 10,
    parameter int HOLD_W = 16
) (
    input  wire logic                ap_clk,
    input  wire logic                ap_rst_n,
    input  wire logic                clear,
    input  wire logic                enable,
    input  wire logic [DATA_W-2:0]   threshold,
    input  wire logic [WIN_W-1:0]    win_len,
    input  wire logic [HOLD_W-1:0]   holdoff_len,
    corr_peak_detector_if.slave      i_data,
    corr_peak_detector_if.master     o_data,
    output logic      [15:0]         peak_count
);

    peak_state_t        r_state;
    logic [CNT_W-1:0]   r_index;
    logic [DATA_W-2:0]  r_best;
    logic [CNT_W-1:0]   r_best_idx;
    logic [WIN_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]  r_hcnt;
    logic               r_tready;
    logic               r_o_valid;
    logic [DATA_W-1:0]  r_o_data;
    logic               r_o_last;
    logic [15:0]        r_peak_count;

    logic [DATA_W-2:0]  w_mag;
    logic               w_accept;
    logic               w_trigger;
    logic               w_short_win;
    logic [WIN_W-1:0]   w_eff_win;
    logic [WIN_W:0]     w_cnt_next;
    logic               w_win_done;
    logic [HOLD_W:0]    w_hcnt_next;
    logic               w_hold_done;
    logic               w_take_new;
    logic [DATA_W-2:0]  w_upd_best;
    logic [CNT_W-1:0]   w_upd_idx;
    logic               w_unused_tlast;

    corr_abs_sat #(
        .DATA_W (DATA_W)
    ) u_abs_sat (
        .data (i_data.TDATA),
        .mag  (w_mag)
    );

    // Input TLAST carries no meaning for a continuous correlation stream
    assign w_unused_tlast = i_data.TLAST;

    assign w_accept    = i_data.TVALID && r_tready;
    assign w_trigger   = enable && (w_mag > threshold);
    assign w_short_win = (win_len <= WIN_W'(1));

    // Window compare is done on the post-increment count against live win_len
    always_comb begin
        w_eff_win   = (win_len == '0) ? WIN_W'(1) : win_len;
        w_cnt_next  = {1'b0, r_cnt} + (WIN_W+1)'(1);
        w_win_done  = (w_cnt_next >= {1'b0, w_eff_win});
        w_hcnt_next = {1'b0, r_hcnt} + (HOLD_W+1)'(1);
        w_hold_done = (w_hcnt_next >= {1'b0, holdoff_len});
        w_take_new  = (w_mag > r_best);
        w_upd_best  = w_take_new ? w_mag   : r_best;
        w_upd_idx   = w_take_new ? r_index : r_best_idx;
    end

    // Peak-search FSM with index/window/holdoff counters and registered outputs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= S_SEARCH;
            r_index      <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_tready     <= 1'b0;
            r_o_valid    <= 1'b0;
            r_o_data     <= '0;
            r_o_last     <= 1'b0;
            r_peak_count <= '0;
        end else if (clear) begin
            // Block-level abort: any pending result is dropped on purpose
            r_state      <= S_SEARCH;
            r_index      <= '0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_tready     <= 1'b1;
            r_o_valid    <= 1'b0;
            r_o_data     <= '0;
            r_o_last     <= 1'b0;
            r_peak_count <= '0;
        end else begin
            if (w_accept) begin
                r_index <= r_index + CNT_W'(1);
            end

            case (r_state)
                S_SEARCH: begin
                    r_tready <= 1'b1;
                    if (w_accept && w_trigger) begin
                        r_best     <= w_mag;
                        r_best_idx <= r_index;
                        r_cnt      <= WIN_W'(1);
                        if (w_short_win) begin
                            r_state   <= S_EMIT_IDX;
                            r_tready  <= 1'b0;
                            r_o_valid <= 1'b1;
                            r_o_data  <= DATA_W'(r_index);
                            r_o_last  <= 1'b0;
                        end else begin
                            r_state <= S_TRACK;
                        end
                    end
                end

                S_TRACK: begin
                    if (w_accept) begin
                        r_cnt      <= w_cnt_next[WIN_W-1:0];
                        r_best     <= w_upd_best;
                        r_best_idx <= w_upd_idx;
                        if (w_win_done) begin
                            r_state   <= S_EMIT_IDX;
                            r_tready  <= 1'b0;
                            r_o_valid <= 1'b1;
                            r_o_data  <= DATA_W'(w_upd_idx);
                            r_o_last  <= 1'b0;
                        end
                    end
                end

                S_EMIT_IDX: begin
                    if (o_data.TREADY) begin
                        r_state  <= S_EMIT_VAL;
                        r_o_data <= DATA_W'(r_best);
                        r_o_last <= 1'b1;
                    end
                end

                S_EMIT_VAL: begin
                    if (o_data.TREADY) begin
                        r_peak_count <= r_peak_count + 16'd1;
                        r_o_valid    <= 1'b0;
                        r_o_data     <= '0;
                        r_o_last     <= 1'b0;
                        r_tready     <= 1'b1;
                        r_hcnt       <= '0;
                        if (holdoff_len != '0) begin
                            r_state <= S_HOLDOFF;
                        end else begin
                            r_state <= S_SEARCH;
                        end
                    end
                end

                S_HOLDOFF: begin
                    if (w_accept) begin
                        r_hcnt <= w_hcnt_next[HOLD_W-1:0];
                        if (w_hold_done) begin
                            r_state <= S_SEARCH;
                        end
                    end
                end

                default: begin
                    r_state   <= S_SEARCH;
                    r_tready  <= 1'b1;
                    r_o_valid <= 1'b0;
                    r_o_last  <= 1'b0;
                end
            endcase
        end
    end

    assign i_data.TREADY = r_tready;
    assign o_data.TVALID = r_o_valid;
    assign o_data.TDATA  = r_o_data;
    assign o_data.TLAST  = r_o_last;
    assign peak_count    = r_peak_count;

endmodule : corr_peak_detector
`default_nettype wire

// File: tb/tb_corr_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corr_peak_detector
//  Description : Directed self-checking bench for corr_peak_detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_corr_peak_detector;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        enable;
    logic [30:0] threshold;
    logic [9:0]  win_len;
    logic [15:0] holdoff_len;
    logic [15:0] peak_count;

    int n_checks;
    int n_errors;

    logic [32:0] q_beats[$];

    corr_peak_detector_if #(.DATA_W(32)) in_if ();
    corr_peak_detector_if #(.DATA_W(32)) out_if ();

    corr_peak_detector #(
        .DATA_W (32),
        .CNT_W  (32),
        .WIN_W  (10),
        .HOLD_W (16)
    ) dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .clear       (clear),
        .enable      (enable),
        .threshold   (threshold),
        .win_len     (win_len),
        .holdoff_len (holdoff_len),
        .i_data      (in_if),
        .o_data      (out_if),
        .peak_count  (peak_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output beat that will complete at the next rising edge
    always @(negedge clk) begin
        if (out_if.TVALID === 1'b1 && out_if.TREADY === 1'b1) begin
            q_beats.push_back({out_if.TLAST, out_if.TDATA});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] v);
        int guard;
        guard = 0;
        in_if.TDATA  = v;
        in_if.TVALID = 1'b1;
        while (in_if.TREADY !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout TREADY=%b want 1", in_if.TREADY);
        end
        @(posedge clk); #1;
        in_if.TVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if ({in_if.TREADY, out_if.TVALID, out_if.TLAST} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags got tready/valid/last=%b want 000",
                     {in_if.TREADY, out_if.TVALID, out_if.TLAST});
        end
        n_checks++;
        if (out_if.TDATA !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_tdata got %0h want 0", out_if.TDATA);
        end
        n_checks++;
        if (peak_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_peak_count got %0d want 0", peak_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        n_checks++;
        if (in_if.TREADY !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_tready_after got %b want 1", in_if.TREADY);
        end
    endtask

    task automatic test_basic();
        logic [32:0] exp_b[2];
        exp_b = '{{1'b0, 32'd3}, {1'b1, 32'd300}};
        threshold = 31'd100; win_len = 10'd4; holdoff_len = 16'd0;
        q_beats.delete();
        push(32'd0); push(32'd0); push(32'd150); push(-32'sd300);
        push(32'd200); push(32'd50); push(32'd0);
        idle(4);
        n_checks++;
        if (q_beats.size() != 2) begin
            n_errors++;
            $display("FAIL basic_beats got %0d want 2", q_beats.size());
        end
        for (int i = 0; i < 2 && i < q_beats.size(); i++) begin
            n_checks++;
            if (q_beats[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL basic_word%0d got %h want %h", i, q_beats[i], exp_b[i]);
            end
        end
        n_checks++;
        if (peak_count !== 16'd1) begin
            n_errors++;
            $display("FAIL basic_peak_count got %0d want 1", peak_count);
        end
    endtask

    task automatic test_tie();
        logic [32:0] exp_b[2];
        exp_b = '{{1'b0, 32'd0}, {1'b1, 32'd20}};
        pulse_clear();
        threshold = 31'd10; win_len = 10'd3; holdoff_len = 16'd0;
        q_beats.delete();
        push(32'd20); push(32'd20); push(32'd20);
        idle(4);
        n_checks++;
        if (q_beats.size() != 2) begin
            n_errors++;
            $display("FAIL tie_beats got %0d want 2", q_beats.size());
        end
        for (int i = 0; i < 2 && i < q_beats.size(); i++) begin
            n_checks++;
            if (q_beats[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL tie_word%0d got %h want %h", i, q_beats[i], exp_b[i]);
            end
        end
        n_checks++;
        if (peak_count !== 16'd1) begin
            n_errors++;
            $display("FAIL tie_peak_count got %0d want 1", peak_count);
        end
    endtask

    task automatic test_holdoff();
        logic [32:0] exp_b[4];
        exp_b = '{{1'b0, 32'd0}, {1'b1, 32'd9}, {1'b0, 32'd3}, {1'b1, 32'd9}};
        pulse_clear();
        threshold = 31'd5; win_len = 10'd1; holdoff_len = 16'd2;
        q_beats.delete();
        push(32'd9); push(32'd9); push(32'd9); push(32'd9);
        idle(4);
        n_checks++;
        if (q_beats.size() != 4) begin
            n_errors++;
            $display("FAIL holdoff_beats got %0d want 4", q_beats.size());
        end
        for (int i = 0; i < 4 && i < q_beats.size(); i++) begin
            n_checks++;
            if (q_beats[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL holdoff_word%0d got %h want %h", i, q_beats[i], exp_b[i]);
            end
        end
        n_checks++;
        if (peak_count !== 16'd2) begin
            n_errors++;
            $display("FAIL holdoff_peak_count got %0d want 2", peak_count);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_b[4];
        exp_b = '{{1'b0, 32'd1}, {1'b1, 32'd200}, {1'b0, 32'd3}, {1'b1, 32'd500}};
        pulse_clear();
        threshold = 31'd100; win_len = 10'd2; holdoff_len = 16'd0;
        out_if.TREADY = 1'b0;
        q_beats.delete();
        push(32'd0); push(32'd200); push(32'd50);
        in_if.TDATA  = 32'd500;
        in_if.TVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_if.TVALID, out_if.TDATA, out_if.TLAST, in_if.TREADY} !== {1'b1, 32'd1, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL bp_hold_cycle%0d got valid=%b data=%0h last=%b tready=%b want 1 1 0 0",
                         i, out_if.TVALID, out_if.TDATA, out_if.TLAST, in_if.TREADY);
            end
            @(posedge clk); #1;
        end
        out_if.TREADY = 1'b1;
        push(32'd500); push(32'd0);
        idle(4);
        n_checks++;
        if (q_beats.size() != 4) begin
            n_errors++;
            $display("FAIL bp_beats got %0d want 4", q_beats.size());
        end
        for (int i = 0; i < 4 && i < q_beats.size(); i++) begin
            n_checks++;
            if (q_beats[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL bp_word%0d got %h want %h", i, q_beats[i], exp_b[i]);
            end
        end
        n_checks++;
        if (peak_count !== 16'd2) begin
            n_errors++;
            $display("FAIL bp_peak_count got %0d want 2", peak_count);
        end
    endtask

    task automatic test_saturation();
        logic [32:0] exp_b[4];
        exp_b = '{{1'b0, 32'd0}, {1'b1, 32'h7FFF_FFFF}, {1'b0, 32'd3}, {1'b1, 32'd101}};
        pulse_clear();
        threshold = 31'h7FFF_FFFE; win_len = 10'd0; holdoff_len = 16'd0;
        q_beats.delete();
        push(32'h8000_0000);
        threshold = 31'd100; win_len = 10'd1;
        push(32'd100); push(-32'sd100); push(32'd101);
        idle(4);
        n_checks++;
        if (q_beats.size() != 4) begin
            n_errors++;
            $display("FAIL sat_beats got %0d want 4", q_beats.size());
        end
        for (int i = 0; i < 4 && i < q_beats.size(); i++) begin
            n_checks++;
            if (q_beats[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL sat_word%0d got %h want %h", i, q_beats[i], exp_b[i]);
            end
        end
        n_checks++;
        if (peak_count !== 16'd2) begin
            n_errors++;
            $display("FAIL sat_peak_count got %0d want 2", peak_count);
        end
    endtask

    task automatic test_clear_and_reset();
        threshold = 31'd10; win_len = 10'd1; holdoff_len = 16'd0;
        out_if.TREADY = 1'b0;
        push(32'd50);
        out_if.TREADY = 1'b1;
        @(posedge clk); #1;
        out_if.TREADY = 1'b0;
        n_checks++;
        if ({out_if.TVALID, out_if.TLAST, out_if.TDATA} !== {1'b1, 1'b1, 32'd50}) begin
            n_errors++;
            $display("FAIL clr_emit_val got valid=%b last=%b data=%0h want 1 1 32",
                     out_if.TVALID, out_if.TLAST, out_if.TDATA);
        end
        pulse_clear();
        n_checks++;
        if ({out_if.TVALID, out_if.TLAST} !== 2'b00 || peak_count !== 16'd0) begin
            n_errors++;
            $display("FAIL clr_after got valid=%b last=%b peak_count=%0d want 0 0 0",
                     out_if.TVALID, out_if.TLAST, peak_count);
        end
        out_if.TREADY = 1'b1;
        q_beats.delete();
        push(32'd30);
        idle(4);
        n_checks++;
        if (q_beats.size() != 2 || q_beats[0] !== {1'b0, 32'd0} || q_beats[1] !== {1'b1, 32'd30}) begin
            n_errors++;
            $display("FAIL clr_next_idx got n=%0d w0=%h want 2 beats {0,30}",
                     q_beats.size(), (q_beats.size() > 0) ? q_beats[0] : 33'h0);
        end
        n_checks++;
        if (peak_count !== 16'd1) begin
            n_errors++;
            $display("FAIL clr_peak_count got %0d want 1", peak_count);
        end

        // Asynchronous reset in the middle of a tracking window
        win_len = 10'd4;
        push(32'd50); push(32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_if.TREADY, out_if.TVALID, out_if.TLAST} !== 3'b000 ||
            out_if.TDATA !== 32'd0 || peak_count !== 16'd0) begin
            n_errors++;
            $display("FAIL async_rst got tready=%b valid=%b last=%b data=%0h pc=%0d want all 0",
                     in_if.TREADY, out_if.TVALID, out_if.TLAST, out_if.TDATA, peak_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        win_len = 10'd1;
        q_beats.delete();
        push(32'd77);
        idle(4);
        n_checks++;
        if (q_beats.size() != 2 || q_beats[0] !== {1'b0, 32'd0} || q_beats[1] !== {1'b1, 32'd77}) begin
            n_errors++;
            $display("FAIL async_rst_restart got n=%0d w0=%h want 2 beats {0,77}",
                     q_beats.size(), (q_beats.size() > 0) ? q_beats[0] : 33'h0);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        enable        = 1'b1;
        threshold     = '0;
        win_len       = '0;
        holdoff_len   = '0;
        in_if.TDATA   = '0;
        in_if.TVALID  = 1'b0;
        in_if.TLAST   = 1'b0;
        out_if.TREADY = 1'b1;

        test_reset();
        test_basic();
        test_tie();
        test_holdoff();
        test_backpressure();
        test_saturation();
        test_clear_and_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_corr_peak_detector
`default_nettype wire
